// File: rtl/otp_macro_cmd_initiator_if.sv
// Shared command/error encodings and the macro command/response channel.
// The master modport is the initiator; the slave modport is the macro.
package otp_macro_cmd_initiator_pkg;
  typedef enum logic [2:0] {
    Read     = 3'b000,
    Write    = 3'b001,
    ReadRaw  = 3'b010,
    WriteRaw = 3'b011,
    Init     = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    NoError              = 3'h0,
    MacroError           = 3'h1,
    MacroEccCorrError    = 3'h2,
    MacroEccUncorrError  = 3'h3,
    MacroWriteBlankError = 3'h4
  } err_e;
endpackage

interface otp_macro_cmd_initiator_if #(
  parameter int Width     = 16,
  parameter int Depth     = 1024,
  parameter int SizeWidth = 2
);
  import otp_macro_cmd_initiator_pkg::*;
  localparam int AddrWidth = $clog2(Depth);
  localparam int IfWidth   = (2**SizeWidth) * Width;

  logic                 otp_ready_i;
  logic                 otp_valid_o;
  cmd_e                 otp_cmd_o;
  logic [SizeWidth-1:0] otp_size_o;
  logic [AddrWidth-1:0] otp_addr_o;
  logic [IfWidth-1:0]   otp_wdata_o;
  logic                 otp_valid_i;
  logic [IfWidth-1:0]   otp_rdata_i;
  err_e                 otp_err_i;

  modport master (
    input  otp_ready_i,
    output otp_valid_o, otp_cmd_o, otp_size_o, otp_addr_o, otp_wdata_o,
    input  otp_valid_i, otp_rdata_i, otp_err_i
  );

  modport slave (
    output otp_ready_i,
    input  otp_valid_o, otp_cmd_o, otp_size_o, otp_addr_o, otp_wdata_o,
    output otp_valid_i, otp_rdata_i, otp_err_i
  );
endinterface

// File: rtl/otp_macro_cmd_initiator.sv
// Sequences Init then single client requests onto the OTP macro, one outstanding
// command at a time, with a response timeout that traps into a terminal error state.
module otp_macro_cmd_initiator
  import otp_macro_cmd_initiator_pkg::*;
#(
  parameter int  Width         = 16,
  parameter int  Depth         = 1024,
  parameter int  SizeWidth     = 2,
  parameter int  TimeoutCycles = 1024,
  localparam int AddrWidth     = $clog2(Depth),
  localparam int IfWidth       = (2**SizeWidth) * Width
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 init_req_i,
  output logic                 init_done_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [SizeWidth-1:0] req_size_i,
  input  logic [IfWidth-1:0]   req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [IfWidth-1:0]   rsp_rdata_o,
  output err_e                 rsp_err_o,
  output logic                 rsp_range_err_o,
  output logic                 fatal_err_o,
  otp_macro_cmd_initiator_if.master otp
);

  localparam int CntWidth = $clog2(TimeoutCycles);

  // Pairwise Hamming distance >= 3 between all legal codes.
  typedef enum logic [5:0] {
    ResetSt    = 6'b000000,
    InitCmdSt  = 6'b000111,
    InitWaitSt = 6'b011001,
    IdleSt     = 6'b101010,
    CmdSt      = 6'b110100,
    WaitSt     = 6'b011110,
    ErrorSt    = 6'b101101
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  cmd_e                 r_cmd;
  cmd_e                 w_cmd;
  logic [SizeWidth-1:0] r_size;
  logic [AddrWidth-1:0] r_addr;
  logic [IfWidth-1:0]   r_wdata;
  logic [CntWidth-1:0]  r_cnt;
  logic                 r_init_done;
  logic                 r_rsp_vld;
  logic [IfWidth-1:0]   r_rsp_rdata;
  err_e                 r_rsp_err;
  logic                 r_rsp_range_err;

  logic                 w_otp_valid;
  logic                 w_idle;
  logic                 w_fatal;
  logic                 w_req_acc;
  logic                 w_range_ok;
  logic [AddrWidth:0]   w_end;
  logic                 w_waiting;
  logic                 w_cnt_expire;
  logic                 w_is_write;

  assign w_end      = {1'b0, req_addr_i} + (AddrWidth+1)'(req_size_i) + (AddrWidth+1)'(1);
  assign w_range_ok = (w_end <= (AddrWidth+1)'(Depth));
  assign w_req_acc  = req_valid_i & req_ready_o;
  assign w_waiting  = (r_state == InitWaitSt) || (r_state == WaitSt);
  // The counter reaches zero on this edge; a response in the same cycle still wins.
  assign w_cnt_expire = (r_cnt == CntWidth'(1)) && !otp.otp_valid_i;
  assign w_is_write   = (r_cmd == Write) || (r_cmd == WriteRaw);

  always_comb begin
    w_cmd = Read;
    case (req_op_i)
      2'b00:   w_cmd = Read;
      2'b01:   w_cmd = Write;
      2'b10:   w_cmd = ReadRaw;
      default: w_cmd = WriteRaw;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ResetSt;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ResetSt:    if (init_req_i) w_state_nxt = InitCmdSt;
      InitCmdSt:  if (otp.otp_ready_i) w_state_nxt = InitWaitSt;
      InitWaitSt: begin
        if (otp.otp_valid_i)   w_state_nxt = IdleSt;
        else if (w_cnt_expire) w_state_nxt = ErrorSt;
      end
      IdleSt:     if (w_req_acc && w_range_ok) w_state_nxt = CmdSt;
      CmdSt:      if (otp.otp_ready_i) w_state_nxt = WaitSt;
      WaitSt: begin
        if (otp.otp_valid_i)   w_state_nxt = IdleSt;
        else if (w_cnt_expire) w_state_nxt = ErrorSt;
      end
      ErrorSt:    w_state_nxt = ErrorSt;
      default:    w_state_nxt = ErrorSt;
    endcase
  end

  always_comb begin
    w_otp_valid = 1'b0;
    w_idle      = 1'b0;
    w_fatal     = 1'b0;
    case (r_state)
      ResetSt, InitWaitSt, WaitSt: ;
      InitCmdSt, CmdSt: w_otp_valid = 1'b1;
      IdleSt:           w_idle      = 1'b1;
      default:          w_fatal     = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd           <= Init;
      r_size          <= '0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_cnt           <= '0;
      r_init_done     <= 1'b0;
      r_rsp_vld       <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_err       <= NoError;
      r_rsp_range_err <= 1'b0;
    end else begin
      r_rsp_vld <= 1'b0;
      if (w_req_acc) begin
        r_cmd   <= w_cmd;
        r_size  <= req_size_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        if (!w_range_ok) begin
          r_rsp_vld       <= 1'b1;
          r_rsp_range_err <= 1'b1;
          r_rsp_err       <= NoError;
          r_rsp_rdata     <= '0;
        end
      end
      if (((r_state == InitCmdSt) || (r_state == CmdSt)) && otp.otp_ready_i) begin
        r_cnt <= CntWidth'(TimeoutCycles - 1);
      end else if (w_waiting && !otp.otp_valid_i && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CntWidth'(1);
      end
      if ((r_state == InitWaitSt) && otp.otp_valid_i) r_init_done <= 1'b1;
      if ((r_state == WaitSt) && otp.otp_valid_i) begin
        r_rsp_vld       <= 1'b1;
        r_rsp_range_err <= 1'b0;
        r_rsp_err       <= otp.otp_err_i;
        r_rsp_rdata     <= w_is_write ? '0 : otp.otp_rdata_i;
      end
    end
  end

  // Holding off the client while a response is presented keeps rsp/req exclusive.
  assign req_ready_o     = w_idle & ~r_rsp_vld;
  assign init_done_o     = r_init_done;
  assign rsp_valid_o     = r_rsp_vld;
  assign rsp_rdata_o     = r_rsp_rdata;
  assign rsp_err_o       = r_rsp_err;
  assign rsp_range_err_o = r_rsp_range_err;
  assign fatal_err_o     = w_fatal;

  assign otp.otp_valid_o = w_otp_valid;
  assign otp.otp_cmd_o   = r_cmd;
  assign otp.otp_size_o  = r_size;
  assign otp.otp_addr_o  = r_addr;
  assign otp.otp_wdata_o = r_wdata;

endmodule
